uart_rx: RTL



---
 rtl/uart_rx.sv | 102 ++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, LSB-first assembly,
// one-cycle valid / frame_err strobes.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int length       = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              rx,
  output logic [length:1]   data,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(length + 1);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

  state_t            r_state, w_nxt_state;
  logic              r_rx_s1, r_rx_s;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit_idx;
  logic [length:1]   r_shift;
  logic              w_half_hit, w_bit_hit, w_last_bit;
  logic              w_shift_en, w_load, w_ferr;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_rx_s1 <= 1'b0;
      r_rx_s  <= 1'b0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s  <= r_rx_s1;
    end
  end

  assign w_half_hit = (r_cnt == CW'(HALF - 1));
  assign w_bit_hit  = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_bit_idx == BW'(length - 1));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_state <= WAIT_IDLE;
    else       r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_shift_en  = 1'b0;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      // Line must be seen high before a start edge is trusted.
      WAIT_IDLE: if (r_rx_s) w_nxt_state = IDLE;
      IDLE:      if (!r_rx_s) w_nxt_state = START;
      START:     if (w_half_hit) w_nxt_state = r_rx_s ? IDLE : DATA;
      DATA: begin
        if (w_bit_hit) begin
          w_shift_en = 1'b1;
          if (w_last_bit) w_nxt_state = STOP;
        end
      end
      STOP: begin
        if (w_bit_hit) begin
          if (r_rx_s) begin
            w_load      = 1'b1;
            w_nxt_state = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_nxt_state = WAIT_IDLE;
          end
        end
      end
      default: w_nxt_state = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_cnt <= (w_nxt_state != r_state) ? '0 : r_cnt + CW'(1);
      if (r_state != DATA)  r_bit_idx <= '0;
      else if (w_shift_en)  r_bit_idx <= r_bit_idx + BW'(1);
      // Right shift in at the MSB so the first received bit ends in bit 1.
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[length:2]};
      if (w_load)     data    <= r_shift;
      valid     <= w_load;
      frame_err <= w_ferr;
    end
  end

  assign busy = (r_state != IDLE);

endmodule
